// File: rtl/i2s_clk_ctrl_if.sv
// Control/status bundle between the I2S clock sequencer and its controller.
// The slave side is the sequencer; the master side supplies run request and config.
interface i2s_clk_ctrl_if #(
  parameter int DIVW = 8,
  parameter int CFGW = 8
);
  logic            en;
  logic [DIVW-1:0] cfg_div;
  logic [CFGW-1:0] cfg_slot;
  logic            sclk;
  logic            lrclk;
  logic            frame_start;
  logic            busy;
  logic [15:0]     frame_ctr;

  modport master (
    output en, cfg_div, cfg_slot,
    input  sclk, lrclk, frame_start, busy, frame_ctr
  );

  modport slave (
    input  en, cfg_div, cfg_slot,
    output sclk, lrclk, frame_start, busy, frame_ctr
  );
endinterface

// File: rtl/i2s_clk_ctrl.sv
// I2S master clock sequencer: derives sclk/lrclk from mclk and starts/stops
// the serial clocks only on frame boundaries so no channel slot is truncated.
module i2s_clk_ctrl #(
  parameter int DW   = 24,
  parameter int DIVW = 8,
  parameter int CFGW = 8
) (
  input logic           clk,
  input logic           rst,
  i2s_clk_ctrl_if.slave bus
);
  localparam int MINSLOT = DW + 1;
  localparam int MINW    = $clog2(MINSLOT + 1);
  localparam int SLW     = (CFGW > MINW) ? CFGW : MINW;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t          state;
  logic [DIVW-1:0] div_eff;
  logic [DIVW-1:0] div_ctr;
  logic [SLW-1:0]  slot_eff;
  logic [SLW-1:0]  bit_ctr;
  logic [SLW-1:0]  slot_req;
  logic            sclk_r;
  logic            lrclk_r;
  logic            fs_r;
  logic            busy_r;
  logic [15:0]     ctr_r;
  logic            div_hit;
  logic            slot_end;

  always_comb begin
    slot_req = SLW'(bus.cfg_slot);
    if (SLW'(bus.cfg_slot) < SLW'(MINSLOT)) slot_req = SLW'(MINSLOT);
    div_hit  = (div_ctr == div_eff);
    slot_end = (bit_ctr == slot_eff - SLW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_eff  <= '0;
      div_ctr  <= '0;
      slot_eff <= '0;
      bit_ctr  <= '0;
      sclk_r   <= 1'b0;
      lrclk_r  <= 1'b1;
      fs_r     <= 1'b0;
      busy_r   <= 1'b0;
      ctr_r    <= '0;
    end else begin
      fs_r <= 1'b0;
      unique case (state)
        IDLE: begin
          sclk_r  <= 1'b0;
          lrclk_r <= 1'b1;
          div_ctr <= '0;
          bit_ctr <= '0;
          busy_r  <= 1'b0;
          if (bus.en) begin
            div_eff  <= bus.cfg_div;
            slot_eff <= slot_req;
            lrclk_r  <= 1'b0;
            fs_r     <= 1'b1;
            busy_r   <= 1'b1;
            ctr_r    <= ctr_r + 16'd1;
            state    <= RUN;
          end
        end
        RUN, DRAIN: begin
          // en only moves between RUN and DRAIN; the clocks never see it
          state <= bus.en ? RUN : DRAIN;
          if (div_hit) begin
            div_ctr <= '0;
            sclk_r  <= ~sclk_r;
            if (sclk_r) begin
              if (slot_end) begin
                bit_ctr <= '0;
                if (state == DRAIN && !bus.en && lrclk_r) begin
                  // right slot complete while draining: park with lrclk high
                  busy_r <= 1'b0;
                  state  <= IDLE;
                end else begin
                  lrclk_r <= ~lrclk_r;
                  if (lrclk_r) begin
                    fs_r  <= 1'b1;
                    ctr_r <= ctr_r + 16'd1;
                  end
                end
              end else begin
                bit_ctr <= bit_ctr + 1'b1;
              end
            end
          end else begin
            div_ctr <= div_ctr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk        = sclk_r;
  assign bus.lrclk       = lrclk_r;
  assign bus.frame_start = fs_r;
  assign bus.busy        = busy_r;
  assign bus.frame_ctr   = ctr_r;
endmodule

// File: doc/i2s_clk_ctrl.md
# i2s_clk_ctrl

Master clock sequencer for the I2S receive path. It derives `sclk` and `lrclk` from the master clock `clk` (mclk), using a runtime divider and slot width. It starts and stops the serial clocks only on frame boundaries, so the downstream I2S receiver never sees a truncated channel slot. It sits beside the receiver, driving its `sclk`/`lrclk` inputs and the external codec, and reports frame-level status to the control logic.

## Interface
- `DW`, default 24: sample width used by the receiver; minimum legal slot is `DW+1` sclk cycles.
- `DIVW`, default 8: width of the divider config.
- `CFGW`, default 8: width of the slot config.

Ports:
- `clk`, in, 1: mclk. Only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: run request; level-sensitive.
- `cfg_div`, in, `DIVW`: sclk half-period in mclk cycles, minus 1.
- `cfg_slot`, in, `CFGW`: sclk cycles per channel slot.
- `sclk`, out, 1: serial bit clock, registered.
- `lrclk`, out, 1: word select, registered; 0 = left/channel 0, 1 = right/channel 1.
- `frame_start`, out, 1: one-cycle pulse coincident with each `lrclk` 1→0 transition.
- `busy`, out, 1: clocks are running (RUN or DRAIN).
- `frame_ctr`, out, 16: count of frames started; wraps.

## Operation
- Reset values: `sclk`=0, `lrclk`=1, `frame_start`=0, `busy`=0, `frame_ctr`=0, state=IDLE, internal counters=0.
- **Effective config** is latched on the IDLE→RUN transition only. Changes while busy are ignored until the next start.
  - `slot_eff = max(cfg_slot, DW+1)`.
  - `div_eff = cfg_div`.
- **div_ctr** counts 0..`div_eff`. At `div_eff` it resets to 0 and `sclk` toggles, giving half-period = `div_eff+1` mclk.
- **bit_ctr** counts sclk falling edges within a slot, 0..`slot_eff-1`. It clears at each `lrclk` toggle.
- `lrclk` toggles only on an sclk falling toggle where `bit_ctr == slot_eff-1`.
- **States:**
  - IDLE: `sclk`=0, `lrclk`=1, counters held at 0. If `en`=1, latch config and go to RUN. In the same cycle register `lrclk`←0, `frame_start`←1, `busy`←1, `frame_ctr`+1.
  - RUN: free-running clocks.
    - Each `lrclk` 1→0 toggle asserts `frame_start` and increments `frame_ctr` (mod 2^16).
    - `en`=0 sampled at any cycle → go to DRAIN, with no change to clock outputs.
  - DRAIN: clocks continue.
    - `en`=1 → return to RUN with no glitch or phase change.
    - At the end-of-frame event (sclk falling toggle, `bit_ctr == slot_eff-1`, `lrclk`=1): `lrclk` stays 1, `sclk`=0, `busy`←0, no `frame_start`, go to IDLE.
- An IDLE cycle with `en`=1 restarts immediately, so the minimum idle gap is 1 mclk.
- Stop always completes the right slot, so every started frame contains two full slots.
- `en` asserted during `rst` is ignored. The first post-reset cycle with `en`=1 starts normally.

## Timing
- Start latency: `en` sampled high in IDLE → `lrclk`=0 and `frame_start`=1 on the next cycle.
- First `sclk` rise occurs `div_eff+1` cycles after `lrclk` falls. The receiver sees MSB on the second rising edge after the `lrclk` edge, per I2S one-bit delay.
- sclk period = 2·(`div_eff+1`) mclk. Frame = 2·`slot_eff` sclk periods = 4·`slot_eff`·(`div_eff+1`) mclk.
- `lrclk` and `frame_start` change in the same cycle as the sclk 1→0 toggle.
- `div_eff`=0 is legal: sclk = mclk/2.
- Stop latency: end of the current right slot, worst case ≈ 1 frame. `busy` falls in the same cycle `sclk` goes to 0 for the last time.
- `rst` mid-frame: all outputs reach their reset values on the next cycle. The truncated slot is acceptable; the receiver is reset alongside.

## Test plan
- `cfg_div`=1, `cfg_slot`=32, `en`=1 from reset release → `frame_start` every 256 clk; `sclk` period 4; `lrclk` high for 128 clk; `frame_ctr`=4 after the 4th pulse.
- `cfg_slot`=10 with `DW`=24 → clamped to 25: `lrclk` half-period = 25 sclk cycles = 100 clk at `cfg_div`=1.
- `en` dropped mid-left-slot → clocks continue through the right slot. Then `lrclk` stays 1, `sclk`=0, `busy`=0, with no extra `frame_start` and `frame_ctr` unchanged.
- `en` dropped then reasserted within the same frame → no gap; `frame_start` spacing unchanged.
- Change `cfg_div` 1→3 while running → period unchanged until stop and restart, after which `sclk` period is 8.
- Loopback with the I2S receiver and a serial source of 0xABCDEF left / 0x123456 right → receiver emits tid 0 = 0xABCDEF and tid 1 = 0x123456 every frame; assert `rst` mid-frame → `sclk`=0, `lrclk`=1, `busy`=0 on the next cycle.
